// File: rtl/uart_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_pkg
//  Description : Shared definitions for the UART transmit arbiter: FSM state
//                encodings, source index constants and the byte width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_arbiter_pkg;

    localparam int c_BYTE_W = 8;
    localparam int c_ST_W   = 2;

    typedef logic [c_ST_W-1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;   // no packet in progress
    localparam state_t c_ST_FETCH = 2'd1;   // waiting for the owner's next byte
    localparam state_t c_ST_GUARD = 2'd2;   // strobe cycle, UART busy not yet visible
    localparam state_t c_ST_DRAIN = 2'd3;   // waiting for the UART to finish

    localparam logic c_SRC0 = 1'b0;
    localparam logic c_SRC1 = 1'b1;

endpackage : uart_tx_arbiter_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter_if
//  Description : Bundles the two source byte streams and the UART transmit
//                handshake seen by the arbiter.
//                slave  : arbiter side (takes requests, drives the UART)
//                master : environment side (sources + UART)
//  Ports       : reqN_valid/byte/last/ready, is_transmitting, transmit,
//                tx_byte, owner, busy, abort
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;

    logic                                   req0_valid;
    logic [uart_tx_arbiter_pkg::c_BYTE_W-1:0] req0_byte;
    logic                                   req0_last;
    logic                                   req0_ready;
    logic                                   req1_valid;
    logic [uart_tx_arbiter_pkg::c_BYTE_W-1:0] req1_byte;
    logic                                   req1_last;
    logic                                   req1_ready;
    logic                                   is_transmitting;
    logic                                   transmit;
    logic [uart_tx_arbiter_pkg::c_BYTE_W-1:0] tx_byte;
    logic                                   owner;
    logic                                   busy;
    logic                                   abort;

    modport slave (
        input  req0_valid, req0_byte, req0_last,
        input  req1_valid, req1_byte, req1_last,
        input  is_transmitting,
        output req0_ready, req1_ready,
        output transmit, tx_byte, owner, busy, abort
    );

    modport master (
        output req0_valid, req0_byte, req0_last,
        output req1_valid, req1_byte, req1_last,
        output is_transmitting,
        input  req0_ready, req1_ready,
        input  transmit, tx_byte, owner, busy, abort
    );

endinterface : uart_tx_arbiter_if
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter2
//  Description : Combinational two-way round-robin arbiter. On a tie the
//                request that did not win last time is granted.
//  Ports       : i_req[1:0]     request lines
//                i_last_winner  index of the previous winner
//                o_grant        granted index (meaningful when o_valid)
//                o_valid        at least one request is present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  wire logic [1:0] i_req,
    input  wire logic       i_last_winner,
    output logic            o_grant,
    output logic            o_valid
);

    assign o_valid = |i_req;
    // Single request: its own index (i_req[1]). Tie: the one that lost last.
    assign o_grant = (&i_req) ? ~i_last_winner : i_req[1];

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Shares one UART transmitter between two byte-stream packet
//                sources. Packet-granular round robin, one byte outstanding
//                at the UART at a time, stall timeout aborts a hung packet.
//  Ports       : clock, reset (sync, active high)
//                bus (uart_tx_arbiter_if.slave): source streams, UART
//                handshake, owner/busy/abort status
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 1023,   // stalled FETCH cycles before abort, 0 = off
    parameter int TW      = 10      // counter width, 2**TW > TIMEOUT
) (
    input  wire logic       clock,
    input  wire logic       reset,
    uart_tx_arbiter_if.slave bus
);

    localparam logic          c_TMO_EN   = (TIMEOUT != 0);
    localparam logic [TW-1:0] c_TMO_LAST = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t                r_state,       w_state_nxt;
    logic                  r_transmit,    w_transmit_nxt;
    logic [c_BYTE_W-1:0]   r_tx_byte,     w_tx_byte_nxt;
    logic                  r_owner,       w_owner_nxt;
    logic                  r_last_winner, w_last_winner_nxt;
    logic                  r_abort,       w_abort_nxt;
    logic                  r_last_flag,   w_last_flag_nxt;
    logic [TW-1:0]         r_count,       w_count_nxt;

    logic                  w_grant;
    logic                  w_any_req;
    logic                  w_own_valid;
    logic [c_BYTE_W-1:0]   w_own_byte;
    logic                  w_own_last;
    logic                  w_fetch_rdy;
    logic                  w_xfer;

    rr_arbiter2 u_rr (
        .i_req         ({bus.req1_valid, bus.req0_valid}),
        .i_last_winner (r_last_winner),
        .o_grant       (w_grant),
        .o_valid       (w_any_req)
    );

    assign w_own_valid = (r_owner == c_SRC1) ? bus.req1_valid : bus.req0_valid;
    assign w_own_byte  = (r_owner == c_SRC1) ? bus.req1_byte  : bus.req0_byte;
    assign w_own_last  = (r_owner == c_SRC1) ? bus.req1_last  : bus.req0_last;

    // Acceptance also waits for the UART to be idle; this is what keeps a
    // byte still in flight after a reset from being overrun.
    assign w_fetch_rdy = (r_state == c_ST_FETCH) && !bus.is_transmitting;
    assign w_xfer      = w_fetch_rdy && w_own_valid;

    assign bus.req0_ready = w_fetch_rdy && (r_owner == c_SRC0);
    assign bus.req1_ready = w_fetch_rdy && (r_owner == c_SRC1);
    assign bus.transmit   = r_transmit;
    assign bus.tx_byte    = r_tx_byte;
    assign bus.owner      = r_owner;
    assign bus.busy       = (r_state != c_ST_IDLE);
    assign bus.abort      = r_abort;

    always_comb begin
        w_state_nxt       = r_state;
        w_transmit_nxt    = 1'b0;
        w_tx_byte_nxt     = r_tx_byte;
        w_owner_nxt       = r_owner;
        w_last_winner_nxt = r_last_winner;
        w_abort_nxt       = 1'b0;
        w_last_flag_nxt   = r_last_flag;
        w_count_nxt       = r_count;

        case (r_state)
            c_ST_IDLE: begin
                if (w_any_req) begin
                    w_owner_nxt = w_grant;
                    w_state_nxt = c_ST_FETCH;
                end
            end
            c_ST_FETCH: begin
                if (w_xfer) begin
                    w_tx_byte_nxt   = w_own_byte;
                    w_transmit_nxt  = 1'b1;
                    w_last_flag_nxt = w_own_last;
                    w_count_nxt     = '0;
                    w_state_nxt     = c_ST_GUARD;
                end else if (w_own_valid) begin
                    // Stall must be consecutive; a present byte held off by
                    // a busy UART restarts the count.
                    w_count_nxt = '0;
                end else if (c_TMO_EN) begin
                    if (r_count == c_TMO_LAST) begin
                        w_abort_nxt       = 1'b1;
                        w_last_winner_nxt = r_owner;
                        w_count_nxt       = '0;
                        w_state_nxt       = c_ST_IDLE;
                    end else begin
                        w_count_nxt = r_count + 1'b1;
                    end
                end
            end
            c_ST_GUARD: begin
                // UART busy rises one cycle after the strobe, so it is not
                // trusted here.
                w_state_nxt = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (!bus.is_transmitting) begin
                    if (r_last_flag) begin
                        w_last_winner_nxt = r_owner;
                        w_state_nxt       = c_ST_IDLE;
                    end else begin
                        w_state_nxt = c_ST_FETCH;
                    end
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_transmit    <= 1'b0;
            r_tx_byte     <= '0;
            r_owner       <= c_SRC0;
            r_last_winner <= c_SRC1;
            r_abort       <= 1'b0;
            r_last_flag   <= 1'b0;
            r_count       <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_transmit    <= w_transmit_nxt;
            r_tx_byte     <= w_tx_byte_nxt;
            r_owner       <= w_owner_nxt;
            r_last_winner <= w_last_winner_nxt;
            r_abort       <= w_abort_nxt;
            r_last_flag   <= w_last_flag_nxt;
            r_count       <= w_count_nxt;
        end
    end

endmodule : uart_tx_arbiter
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Directed testbench for uart_tx_arbiter (TIMEOUT = 8). The
//                UART model raises is_transmitting one cycle after a strobe
//                and holds it for four cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.TIMEOUT(8), .TW(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // UART model
    int   uart_cnt = 0;
    logic ext_busy = 1'b0;
    always @(posedge clock) begin
        if (bus.transmit === 1'b1) uart_cnt <= 4;
        else if (uart_cnt != 0)    uart_cnt <= uart_cnt - 1;
    end
    assign bus.is_transmitting = (uart_cnt != 0) || ext_busy;

    // Sources: queue of {last, byte}; a byte leaves its queue once taken
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic       pend0 = 1'b0;
    logic       pend1 = 1'b0;
    always @(negedge clock) begin
        logic [8:0] h;
        if (pend0) void'(q0.pop_front());
        if (pend1) void'(q1.pop_front());
        h = (q0.size() != 0) ? q0[0] : 9'h000;
        bus.req0_valid = (q0.size() != 0);
        bus.req0_byte  = h[7:0];
        bus.req0_last  = h[8];
        h = (q1.size() != 0) ? q1[0] : 9'h000;
        bus.req1_valid = (q1.size() != 0);
        bus.req1_byte  = h[7:0];
        bus.req1_last  = h[8];
        pend0 = bus.req0_valid && (bus.req0_ready === 1'b1) && !reset;
        pend1 = bus.req1_valid && (bus.req1_ready === 1'b1) && !reset;
    end

    // Monitor
    typedef struct packed {
        logic [31:0] c;
        logic [7:0]  b;
        logic        o;
    } ev_t;
    ev_t  log_q[$];
    int   ab_cyc[$];
    logic ab_busy[$];
    int   dbl       = 0;
    logic prev_tx   = 1'b0;
    int   rdy_seen  = 0;
    logic watch_rdy = 1'b0;
    always @(negedge clock) begin
        if (bus.transmit === 1'b1) begin
            log_q.push_back({32'(cyc), bus.tx_byte, bus.owner});
            if (prev_tx) dbl++;
        end
        prev_tx = (bus.transmit === 1'b1);
        if (bus.abort === 1'b1) begin
            ab_cyc.push_back(cyc);
            ab_busy.push_back(bus.busy);
        end
        if (watch_rdy && ((bus.req0_ready === 1'b1) || (bus.req1_ready === 1'b1))) rdy_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_log(input int n);
        int k = 0;
        while (log_q.size() < n && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("wait_log", 32'(log_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((q0.size() != 0 || q1.size() != 0 || bus.busy !== 1'b0 || uart_cnt != 0) && k < 3000) begin
            @(negedge clock);
            k++;
        end
        chk("wait_idle", 32'(k < 3000), 32'd1);
    endtask

    task automatic chk_ev(input string tag, input int i, input logic [7:0] b, input logic o);
        if (i < log_q.size()) begin
            chk({tag, "_byte"},  32'(log_q[i].b), 32'(b));
            chk({tag, "_owner"}, 32'(log_q[i].o), 32'(o));
        end else begin
            chk({tag, "_present"}, 32'd0, 32'd1);
        end
    endtask

    function automatic int gap(input int i);
        if (i + 1 < log_q.size()) return int'(log_q[i+1].c - log_q[i].c);
        return -1;
    endfunction

    function automatic int ab_gap_after_strobe();
        if (ab_cyc.size() > 0 && log_q.size() > 0) return ab_cyc[0] - int'(log_q[0].c);
        return -1;
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_transmit"}, 32'(bus.transmit),   32'd0);
        chk({tag, "_tx_byte"},  32'(bus.tx_byte),    32'd0);
        chk({tag, "_owner"},    32'(bus.owner),      32'd0);
        chk({tag, "_busy"},     32'(bus.busy),       32'd0);
        chk({tag, "_abort"},    32'(bus.abort),      32'd0);
        chk({tag, "_ready0"},   32'(bus.req0_ready), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req0_valid = 1'b0; bus.req0_byte = 8'h00; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_byte = 8'h00; bus.req1_last = 1'b0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk_reset_outputs("rst");
        reset = 1'b0;

        // Single three-byte packet from source 0
        step();
        q0.push_back({1'b0, 8'h42});
        q0.push_back({1'b0, 8'h43});
        q0.push_back({1'b1, 8'h44});
        wait_log(3);
        wait_idle();
        chk("t1_count", 32'(log_q.size()), 32'd3);
        chk_ev("t1_b0", 0, 8'h42, 1'b0);
        chk_ev("t1_b1", 1, 8'h43, 1'b0);
        chk_ev("t1_b2", 2, 8'h44, 1'b0);
        chk("t1_gap01", 32'(gap(0)), 32'd7);
        chk("t1_gap12", 32'(gap(1)), 32'd7);
        chk("t1_busy",  32'(bus.busy),  32'd0);
        chk("t1_owner", 32'(bus.owner), 32'd0);

        // Tie right after source 0 won: source 1 must go first
        log_q.delete();
        step();
        q0.push_back({1'b1, 8'hA0});
        q1.push_back({1'b1, 8'hB1});
        wait_log(2);
        wait_idle();
        chk_ev("t2_first",  0, 8'hB1, 1'b1);
        chk_ev("t2_second", 1, 8'hA0, 1'b0);

        // Tie from reset: source 0 wins first
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        log_q.delete();
        q0.push_back({1'b1, 8'hCD});
        q1.push_back({1'b0, 8'h10});
        q1.push_back({1'b1, 8'h46});
        wait_log(3);
        wait_idle();
        chk_ev("t3_cd", 0, 8'hCD, 1'b0);
        chk_ev("t3_10", 1, 8'h10, 1'b1);
        chk_ev("t3_46", 2, 8'h46, 1'b1);
        chk("t3_gap_switch", 32'(gap(0)), 32'd8);
        chk("t3_gap_pkt",    32'(gap(1)), 32'd7);

        // Source 1 arrives mid-packet: no interleave
        log_q.delete();
        step();
        q0.push_back({1'b0, 8'h01});
        q0.push_back({1'b0, 8'h02});
        q0.push_back({1'b1, 8'h03});
        wait_log(1);
        step();
        q1.push_back({1'b0, 8'hA1});
        q1.push_back({1'b1, 8'hA2});
        wait_log(5);
        wait_idle();
        chk_ev("t4_e0", 0, 8'h01, 1'b0);
        chk_ev("t4_e1", 1, 8'h02, 1'b0);
        chk_ev("t4_e2", 2, 8'h03, 1'b0);
        chk_ev("t4_e3", 3, 8'hA1, 1'b1);
        chk_ev("t4_e4", 4, 8'hA2, 1'b1);

        // Next tie after source 1 finished: source 0 wins
        log_q.delete();
        step();
        q0.push_back({1'b1, 8'h55});
        q1.push_back({1'b1, 8'h66});
        wait_log(2);
        wait_idle();
        chk_ev("t4_tie0", 0, 8'h55, 1'b0);
        chk_ev("t4_tie1", 1, 8'h66, 1'b1);

        // Timeout: source 0 stalls after one non-final byte
        log_q.delete();
        ab_cyc.delete();
        ab_busy.delete();
        step();
        q0.push_back({1'b0, 8'h0E});
        wait_log(1);
        step();
        q1.push_back({1'b1, 8'h77});
        wait_log(2);
        wait_idle();
        chk("t5_abort_count", 32'(ab_cyc.size()), 32'd1);
        chk("t5_abort_delay", 32'(ab_gap_after_strobe()), 32'd14);
        chk("t5_abort_idle",  32'((ab_busy.size() > 0) ? ab_busy[0] : 1'b1), 32'd0);
        chk_ev("t5_e0", 0, 8'h0E, 1'b0);
        chk_ev("t5_e1", 1, 8'h77, 1'b1);
        chk("t5_regrant", 32'((log_q.size() > 1 && ab_cyc.size() > 0) ? int'(log_q[1].c) - ab_cyc[0] : -1), 32'd2);

        // UART held busy externally: nothing may be accepted or sent
        log_q.delete();
        ab_cyc.delete();
        ab_busy.delete();
        step();
        ext_busy = 1'b1;
        q0.push_back({1'b1, 8'h99});
        watch_rdy = 1'b1;
        repeat (20) step();
        chk("t6_ready",   32'(rdy_seen),       32'd0);
        chk("t6_no_tx",   32'(log_q.size()),   32'd0);
        chk("t6_busy",    32'(bus.busy),       32'd1);
        chk("t6_noabort", 32'(ab_cyc.size()),  32'd0);
        watch_rdy = 1'b0;
        ext_busy  = 1'b0;
        wait_log(1);
        wait_idle();
        chk_ev("t6_e0", 0, 8'h99, 1'b0);

        // Reset while draining: outputs clear, next byte waits for the UART
        log_q.delete();
        step();
        q0.push_back({1'b0, 8'hB0});
        q0.push_back({1'b1, 8'hB1});
        wait_log(1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        step();
        chk_reset_outputs("t7");
        reset = 1'b0;
        wait_log(2);
        wait_idle();
        chk_ev("t7_e0", 0, 8'hB0, 1'b0);
        chk_ev("t7_e1", 1, 8'hB1, 1'b0);
        chk("t7_gap", 32'(gap(0)), 32'd6);

        chk("no_back_to_back", 32'(dbl), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_uart_tx_arbiter
`default_nettype wire
